// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg
// Shared types and helpers for the multicycle multiply/divide unit.
//   mdu_op_e    : RISC-V M-extension funct3 encodings
//   mdu_state_e : control FSM states
//   is_div / is_rem / is_signed_a / is_signed_b : op decode helpers
// -----------------------------------------------------------------------------
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_e;

    function automatic logic is_div(input mdu_op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic is_rem(input mdu_op_e op);
        return op inside {OP_REM, OP_REMU};
    endfunction

    // rs1 is treated as signed
    function automatic logic is_signed_a(input mdu_op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    // rs2 is treated as signed
    function automatic logic is_signed_b(input mdu_op_e op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/mdu_negate.sv
// -----------------------------------------------------------------------------
// mdu_negate
// Combinational conditional two's-complement negation.
//   din  [W-1:0] : input value
//   neg          : 1 -> dout = -din, 0 -> dout = din
//   dout [W-1:0] : result
// -----------------------------------------------------------------------------
module mdu_negate #(
    parameter int W = 64
) (
    input  logic [W-1:0] din,
    input  logic         neg,
    output logic [W-1:0] dout
);

    assign dout = neg ? ((~din) + W'(1)) : din;

endmodule

// File: rtl/mul_div_unit.sv
// -----------------------------------------------------------------------------
// mul_div_unit
// Multicycle RISC-V M-extension unit: shift-add multiply and restoring
// divide, one bit per cycle, operating on magnitudes with a final sign fix.
//   CLK, RST          : clock (rising edge), asynchronous active-high reset
//   START, OP, A, B   : issue request (sampled only in IDLE), funct3, rs1, rs2
//   BUSY              : high in every state except IDLE
//   DONE              : one-cycle pulse, RESULT valid
//   RESULT            : result register, held until the next DONE
// Optional build macro: MDU_EARLY_OUT_EN -- multiply ops leave CALC as soon
// as the remaining multiplier bits are all zero.
// -----------------------------------------------------------------------------
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            START,
    input  logic [2:0]      OP,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic            BUSY,
    output logic            DONE,
    output logic [XLEN-1:0] RESULT
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN);
    localparam logic [XLEN-1:0]  MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_e            state_q, state_d;
    mdu_op_e               op_q, op_d;
    logic [2*XLEN-1:0]     acc_q, acc_d;     // mul: {partial, multiplier}; div: low half = dividend/quotient
    logic [XLEN-1:0]       rem_q, rem_d;     // div partial remainder (always < divisor)
    logic [XLEN-1:0]       opb_q, opb_d;     // mul: multiplicand; div: divisor
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  sign_q, sign_d;
    logic [XLEN-1:0]       result_q, result_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    // ---------------- issue-side decode ----------------
    mdu_op_e         op_in;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, div_ovf;

    assign op_in    = mdu_op_e'(OP);
    assign a_neg    = is_signed_a(op_in) & A[XLEN-1];
    assign b_neg    = is_signed_b(op_in) & B[XLEN-1];
    assign div_zero = (B == '0);
    assign div_ovf  = (op_in inside {OP_DIV, OP_REM}) && (A == MOST_NEG) && (B == '1);

    mdu_negate #(.W(XLEN)) u_abs_a (.din(A), .neg(a_neg), .dout(a_mag));
    mdu_negate #(.W(XLEN)) u_abs_b (.din(B), .neg(b_neg), .dout(b_mag));

    // ---------------- datapath steps ----------------
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_shift, div_diff;
    logic              div_ge;

    // Add multiplicand into the upper half when the multiplier LSB is set,
    // then shift the whole accumulator right (carry enters the MSB).
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

    // Restoring step: shift next dividend bit into the remainder, try subtract.
    assign div_shift = {rem_q, acc_q[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, opb_q};
    assign div_ge    = ~div_diff[XLEN];

`ifdef MDU_EARLY_OUT_EN
    // Low cnt_q bits of the accumulator are the multiplier bits not yet consumed.
    logic [XLEN-1:0] rem_mask;
    logic            mul_zero;
    assign rem_mask = {XLEN{1'b1}} >> (CNT_INIT - cnt_q);
    assign mul_zero = ((acc_q[XLEN-1:0] & rem_mask) == '0);
`endif

    // ---------------- result sign fix ----------------
    // Negate the full double-width product so the high half is correct.
    logic [2*XLEN-1:0] fix_in, fix_out;
    logic [XLEN-1:0]   fix_sel;

    assign fix_in  = is_div(op_q) ? {{XLEN{1'b0}}, (is_rem(op_q) ? rem_q : acc_q[XLEN-1:0])} : acc_q;
    assign fix_sel = (op_q inside {OP_MULH, OP_MULHSU, OP_MULHU}) ? fix_out[2*XLEN-1:XLEN]
                                                                  : fix_out[XLEN-1:0];

    mdu_negate #(.W(2*XLEN)) u_fix (.din(fix_in), .neg(sign_q), .dout(fix_out));

    // ---------------- control ----------------
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        opb_d    = opb_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
        result_d = result_q;

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    op_d = op_in;
                    if (is_div(op_in) && (div_zero || div_ovf)) begin
                        // Architecturally defined results, no iteration needed.
                        if (div_zero) result_d = is_rem(op_in) ? A : '1;
                        else          result_d = is_rem(op_in) ? '0 : A;
                        state_d = ST_DONE;
                    end else begin
                        acc_d   = {{XLEN{1'b0}}, (is_div(op_in) ? a_mag : b_mag)};
                        opb_d   = is_div(op_in) ? b_mag : a_mag;
                        rem_d   = '0;
                        cnt_d   = CNT_INIT;
                        // Remainder takes the dividend's sign.
                        sign_d  = is_rem(op_in) ? a_neg : (a_neg ^ b_neg);
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (is_div(op_q)) begin
                    acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], div_ge};
                    rem_d = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
                end else begin
                    acc_d = mul_next;
                end
                if (cnt_q == CNT_W'(1)) state_d = ST_FIX;
`ifdef MDU_EARLY_OUT_EN
                if (!is_div(op_q) && mul_zero) begin
                    // Nothing left to add: jump straight to final alignment.
                    acc_d   = acc_q >> cnt_q;
                    state_d = ST_FIX;
                end
`endif
            end
            ST_FIX: begin
                result_d = fix_sel;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_MUL;
            acc_q    <= '0;
            rem_q    <= '0;
            opb_q    <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            opb_q    <= opb_d;
            cnt_q    <= cnt_d;
            sign_q   <= sign_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign BUSY   = busy_q;
    assign DONE   = done_q;
    assign RESULT = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mul_div_unit
// Directed + random checks of mul_div_unit at XLEN=64. Expected results are
// queued at issue and popped when DONE is observed. Honours MDU_EARLY_OUT_EN
// for multiply latency.
// -----------------------------------------------------------------------------
module tb_mul_div_unit;

    localparam int          XLEN     = 64;
    localparam logic [63:0] MOST_NEG = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ALL1     = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic [2:0]  OP;
    logic [63:0] A, B;
    logic        BUSY, DONE;
    logic [63:0] RESULT;

    int checks   = 0;
    int failures = 0;
    logic [63:0] exp_q[$];

    always #5 CLK = ~CLK;

    mul_div_unit #(.XLEN(XLEN)) dut (
        .CLK(CLK), .RST(RST), .START(START), .OP(OP), .A(A), .B(B),
        .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model built from wide products and language division.
    function automatic logic [63:0] ref_f(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [127:0]       ps, psu, pu;
        logic signed [63:0] sa, sb, sq;
        sa  = a;
        sb  = b;
        ps  = {{64{a[63]}}, a} * {{64{b[63]}}, b};
        psu = {{64{a[63]}}, a} * {64'b0, b};
        pu  = {64'b0, a} * {64'b0, b};
        case (op)
            3'd0: return pu[63:0];
            3'd1: return ps[127:64];
            3'd2: return psu[127:64];
            3'd3: return pu[127:64];
            3'd4: begin
                if (b == 0) return ALL1;
                if (a == MOST_NEG && b == ALL1) return a;
                sq = sa / sb;
                return sq;
            end
            3'd5: return (b == 0) ? ALL1 : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == MOST_NEG && b == ALL1) return 64'd0;
                sq = sa % sb;
                return sq;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Issue one op, scramble inputs after the sampling edge, wait for DONE.
    // pulse_edge > 0 re-asserts START (with junk operands) on that edge.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp, input int pulse_edge);
        int          edges;
        logic        busy_ok;
        logic [63:0] want;
        @(negedge CLK);
        START = 1'b1; OP = op; A = a; B = b;
        exp_q.push_back(exp);
        @(posedge CLK); #1;
        edges   = 1;
        busy_ok = (BUSY === 1'b1);
        START = 1'b0; OP = 3'($urandom); A = {$urandom, $urandom}; B = {$urandom, $urandom};
        while (DONE !== 1'b1 && edges < 200) begin
            START = (edges == pulse_edge - 1);
            @(posedge CLK); #1;
            edges++;
            START   = 1'b0;
            busy_ok = busy_ok & (BUSY === 1'b1);
        end
        want = exp_q.pop_front();
        check({tag, "_result"}, RESULT, want);
`ifdef MDU_EARLY_OUT_EN
        if (!op[2]) check({tag, "_lat_max"}, 64'(edges <= XLEN + 2), 64'd1);
        else
`endif
        check({tag, "_latency"}, 64'(edges),
              64'((op[2] && (b == 0 || (!op[0] && a == MOST_NEG && b == ALL1))) ? 1 : XLEN + 2));
        check({tag, "_busy"}, 64'(busy_ok), 64'd1);
        @(posedge CLK); #1;
        check({tag, "_idle"}, 64'({DONE, BUSY}), 64'd0);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [63:0] ra, rb;
        logic        done_seen;

        RST = 1'b1; START = 1'b0; OP = 3'd0; A = '0; B = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_busy",   64'(BUSY), 64'd0);
        check("rst_done",   64'(DONE), 64'd0);
        check("rst_result", RESULT,    64'd0);
        @(negedge CLK);
        RST = 1'b0;

        // Directed cases
        run_op("mulhu_max_2",   3'd3, ALL1,      64'd2,  64'd1, 0);
        run_op("div_m7_2",      3'd4, -64'sd7,   64'd2,  64'hFFFF_FFFF_FFFF_FFFD, 0);
        run_op("rem_m7_2",      3'd6, -64'sd7,   64'd2,  ALL1, 0);
        run_op("mulh_m1_m1",    3'd1, ALL1,      ALL1,   64'd0, 0);
        run_op("mul_m1_m1",     3'd0, ALL1,      ALL1,   64'd1, 0);
        run_op("divu_5_0",      3'd5, 64'd5,     64'd0,  ALL1, 0);
        run_op("remu_5_0",      3'd7, 64'd5,     64'd0,  64'd5, 0);
        run_op("div_ovf",       3'd4, MOST_NEG,  ALL1,   MOST_NEG, 0);
        run_op("rem_ovf",       3'd6, MOST_NEG,  ALL1,   64'd0, 0);
        run_op("mulhsu_m1_2",   3'd2, ALL1,      64'd2,  ALL1, 0);
        run_op("mulh_min_min",  3'd1, MOST_NEG,  MOST_NEG, 64'h4000_0000_0000_0000, 0);
        run_op("divu_max_3",    3'd5, ALL1,      64'd3,  64'h5555_5555_5555_5555, 0);
        run_op("div_7_m2",      3'd4, 64'd7,     -64'sd2, 64'hFFFF_FFFF_FFFF_FFFD, 0);
        run_op("rem_7_m2",      3'd6, 64'd7,     -64'sd2, 64'd1, 0);
        run_op("remu_100_7",    3'd7, 64'd100,   64'd7,  64'd2, 0);
        run_op("mul_123_0",     3'd0, 64'd123,   64'd0,  64'd0, 0);
        run_op("mul_123_1",     3'd0, 64'd123,   64'd1,  64'd123, 0);
        run_op("div_0_5",       3'd4, 64'd0,     64'd5,  64'd0, 0);
        run_op("div_zero_s",    3'd4, -64'sd9,   64'd0,  ALL1, 0);

        // Random cases against the reference model
        for (int i = 0; i < 36; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = {$urandom, $urandom};
            rb  = {$urandom, $urandom};
            if (i % 9 == 0)  rb = 64'd0;
            if (i % 4 == 1)  rb = 64'($urandom_range(1, 15));
            if (i % 13 == 5) begin ra = MOST_NEG; rb = ALL1; end
            run_op("rand", rop, ra, rb, ref_f(rop, ra, rb), 0);
        end

        // START re-pulsed mid-CALC must be ignored
        run_op("busy_start", 3'd0, 64'd3, 64'd5, 64'd15, 20);

        // Asynchronous reset aborts an in-flight divide
        @(negedge CLK);
        START = 1'b1; OP = 3'd5; A = 64'd100; B = 64'd7;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (28) @(posedge CLK);
        #1;
        check("abort_pre_busy", 64'(BUSY), 64'd1);
        @(posedge CLK); #2;
        RST = 1'b1;
        #1;
        check("abort_busy",   64'(BUSY), 64'd0);
        check("abort_done",   64'(DONE), 64'd0);
        check("abort_result", RESULT,    64'd0);
        @(negedge CLK);
        RST = 1'b0;
        done_seen = 1'b0;
        repeat (80) begin
            @(posedge CLK); #1;
            if (DONE === 1'b1) done_seen = 1'b1;
        end
        check("abort_no_done", 64'(done_seen), 64'd0);
        check("abort_hold",    RESULT,         64'd0);

        run_op("post_rst_div", 3'd4, 64'd7, -64'sd2, 64'hFFFF_FFFF_FFFF_FFFD, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run can never hang.
    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
